// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: sweeps all 128 values of x into a 7-input function and captures its 128-bit truth table.
// Optional popcount output `ones` is built when TT_POPCOUNT_EN is defined.
module tt_sweep_capture #(
    parameter int DUT_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic [6:0]   x,
    input  logic         f_out,
    output logic         tt_valid,
    input  logic         tt_ready,
    output logic [127:0] tt
`ifdef TT_POPCOUNT_EN
    ,
    output logic [7:0]   ones
`endif
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, HOLD} state_t;

    state_t         state_q, state_d;
    logic [6:0]     idx_q, idx_d;
    logic [127:0]   tt_q, tt_d;
    logic           cap_v;
    logic [6:0]     cap_idx;

    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cap_v   = state_q == SWEEP;
            assign cap_idx = idx_q;
        end else begin : g_pipe
            logic [7:0] tag_q [DUT_LAT];
            logic [7:0] tag_d [DUT_LAT];
            // Tag shift register: {valid, idx} delayed to line up with f_out
            always_comb begin
                tag_d[0] = {state_q == SWEEP, idx_q};
                for (int k = 1; k < DUT_LAT; k++) tag_d[k] = tag_q[k-1];
            end
            // Tag pipeline register, invalid after reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tag_q <= '{default: '0};
                else        tag_q <= tag_d;
            end
            assign cap_v   = tag_q[DUT_LAT-1][7];
            assign cap_idx = tag_q[DUT_LAT-1][6:0];
        end
    endgenerate

    // Next-state, index advance and truth-table capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tt_d    = tt_q;
        if (cap_v) tt_d[cap_idx] = f_out;
        case (state_q)
            IDLE:    if (start) begin
                         state_d = SWEEP;
                         idx_d   = '0;
                         tt_d    = '0;
                     end
            SWEEP:   if (idx_q == 7'd127) state_d = (DUT_LAT > 0) ? DRAIN : HOLD;
                     else                 idx_d   = idx_q + 7'd1;
            DRAIN:   if (cap_v && cap_idx == 7'd127) state_d = HOLD;
            HOLD:    if (tt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and table registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
        end
    end

`ifdef TT_POPCOUNT_EN
    logic [7:0] ones_q, ones_d;
    // Running count of captured ones, cleared when a sweep starts
    always_comb begin
        ones_d = ones_q;
        if (state_q == IDLE && start) ones_d = '0;
        else if (cap_v)               ones_d = ones_q + {7'd0, f_out};
    end
    // Popcount register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ones_q <= '0;
        else        ones_q <= ones_d;
    end
    assign ones = ones_q;
`endif

    assign busy     = state_q == SWEEP || state_q == DRAIN;
    assign x        = busy ? idx_q : 7'd0;
    assign tt_valid = state_q == HOLD;
    assign tt       = tt_q;
endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

- Exhaustive stimulus-and-capture stage for 7-input classification functions.
- Drives all 128 input combinations into a combinational (or fixed-latency) function block on `x[6:0]`.
- Samples the block's single-bit `out` on `f_out` and assembles the 128-bit truth table.
- Presents the table through a valid/ready handshake for signature comparison.

## Interface
Parameters:
- `DUT_LAT`, default 0: cycles from `x` change to corresponding `f_out`; range 0–7. 0 = purely combinational block.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous, active-low.
- `start`: input, 1 bit. Begin a sweep; honoured only in IDLE.
- `busy`: output, 1 bit. High in SWEEP and DRAIN.
- `x`: output, 7 bits. Drives the function block; `x[k]` feeds input `xk`.
- `f_out`: input, 1 bit. Function block output.
- `tt_valid`: output, 1 bit. Truth table complete and stable.
- `tt_ready`: input, 1 bit. Consumer accepts the table.
- `tt`: output, 128 bits. `tt[i]` = `f_out` response to `x == i`.
- `ones`: output, 8 bits. Population count of `tt`. Present only with `TT_POPCOUNT_EN`.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, HOLD.
- **IDLE**
  - `x`=0; `busy`=0; `tt_valid`=0.
  - `start`=1 → SWEEP. On that edge, clear `idx`=0, `tt`=0 and `ones`=0.
- **SWEEP**
  - `x`=`idx` each cycle; `idx` increments by 1.
  - When `x`=127 is presented → DRAIN if `DUT_LAT`>0, else → HOLD.
- **DRAIN**
  - Lasts exactly `DUT_LAT` cycles; `x` holds 127.
  - Then → HOLD.
- **Capture pipeline**
  - Tag shift register holds {valid, idx[6:0]}, depth `DUT_LAT`.
  - On each edge where the delayed tag is valid: `tt[tag_idx]` <= `f_out`, and `ones` += `f_out`.
  - With `DUT_LAT`=0, the tag is the current `idx` in SWEEP.
- **HOLD**
  - `tt_valid`=1; `tt` and `ones` frozen.
  - `tt_valid` & `tt_ready` → IDLE. The table stays readable on `tt` until the next accepted `start`.
- `start` is ignored outside IDLE, including in HOLD.
- `idx` is 7 bits and never wraps within a sweep; exactly 128 captures per sweep.
- `ones` is 8 bits and saturates naturally at 128 (no overflow possible).

## Timing
- Reset values:
  - State IDLE; `idx`=0; tag pipeline invalid.
  - Outputs: `x`=0, `busy`=0, `tt_valid`=0, `tt`=0, `ones`=0.
- Edge E0 samples `start`=1 in IDLE.
  - `x`=0 from after E0; `x`=i after edge E(i).
- Capture of index i occurs at edge E(i+1+`DUT_LAT`).
- `tt_valid` rises after edge E(128+`DUT_LAT`). Latency = 128+`DUT_LAT` cycles from start edge.
- `busy` is high from after E0 to after E(128+`DUT_LAT`).
- `tt_valid` drops the cycle after the handshake edge.
  - Earliest next `start` is sampled the cycle after that.
- Reset mid-operation: `rst_n` low in any state immediately forces reset values. No partial table is ever presented.
- `tt_ready` held high before HOLD has no effect. Handshake completes on the first HOLD cycle.

## Configuration
- Macro: `TT_POPCOUNT_EN`.
- Defined:
  - `ones[7:0]` port exists.
  - Accumulated incrementally at each capture.
  - Valid whenever `tt_valid`=1.
- Undefined:
  - Port and accumulator are absent.
  - All other behaviour is identical.

## Test plan
- Constant-0 function, `DUT_LAT`=0, `tt_ready`=1:
  - `start` pulse → `tt_valid` after exactly 128 cycles.
  - `tt`=0, `ones`=0.
- Function `out`=x0:
  - `tt`=0xAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA.
  - `ones`=64.
  - `x` sequence observed 0,1,…,127.
- Majority-network model:
  - `tt`=0xFEFEFEA8FEE8E880FEE8E880EA808080.
  - `ones`=64.
- `DUT_LAT`=2, model `out`=x6 registered twice:
  - `tt`=0xFFFFFFFFFFFFFFFF0000000000000000.
  - `tt_valid` after 130 cycles.
  - `busy` high for 130 cycles.
- Handshake and reset:
  - Hold `tt_ready`=0 for 10 cycles in HOLD → `tt` stable, `tt_valid`=1 throughout.
  - `start` pulses during SWEEP and HOLD are ignored.
  - Assert `rst_n`=0 at `idx`=50 of a new sweep → all outputs return to 0 immediately.
  - A fresh sweep afterwards yields the correct table.
